pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard and data-memory handshake controller.
// Arbitrates memory stalls, load-use bubbles and branch flushes.
module pipeline_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RDaddr_i,
    input  logic [4:0]       IFID_RS1addr_i,
    input  logic [4:0]       IFID_RS2addr_i,
    input  logic             Branch_taken_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             MEMWB_Bubble_o,
    output logic             IDEX_Hold_o,
    output logic             EXMEM_Hold_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          memop;
    logic          mem_stall;
    logic          load_use;
    logic          rd_match;

    // Request, stall and hazard detection
    always_comb begin
        memop     = EXMEM_MemRead_i | EXMEM_MemWrite_i;
        mem_req_o = start_i &
                    (((state == IDLE) & memop) | (state == BUSY));
        mem_stall = (mem_req_o & ~mem_ack_i) | (state == ERR);
        rd_match  = (IDEX_RDaddr_i == IFID_RS1addr_i) |
                    (IDEX_RDaddr_i == IFID_RS2addr_i);
        load_use  = IDEX_MemRead_i & (IDEX_RDaddr_i != 5'd0) & rd_match;
    end

    // Pipeline register controls, memory stall outranks load-use outranks branch
    always_comb begin
        PCWrite_o      = 1'b1;
        IFID_Write_o   = 1'b1;
        IFID_Flush_o   = 1'b0;
        IDEX_Bubble_o  = 1'b0;
        MEMWB_Bubble_o = 1'b0;
        IDEX_Hold_o    = 1'b0;
        EXMEM_Hold_o   = 1'b0;
        if (!start_i) begin
            PCWrite_o      = 1'b0;
            IFID_Write_o   = 1'b0;
            IFID_Flush_o   = 1'b1;
            IDEX_Bubble_o  = 1'b1;
            MEMWB_Bubble_o = 1'b1;
        end else if (mem_stall) begin
            PCWrite_o      = 1'b0;
            IFID_Write_o   = 1'b0;
            IDEX_Hold_o    = 1'b1;
            EXMEM_Hold_o   = 1'b1;
            MEMWB_Bubble_o = 1'b1;
        end else if (load_use) begin
            PCWrite_o     = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else if (Branch_taken_i) begin
            IFID_Flush_o = 1'b1;
        end
    end

    // Memory handshake FSM; wait_cnt counts unacked request cycles
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_req_o && !mem_ack_i) begin
                        state    <= BUSY;
                        wait_cnt <= WW'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WW'(TIMEOUT)) begin
                        state <= ERR;
                        err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                ERR: begin
                    err_o <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles lost to memory stalls or load-use bubbles
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            stall_cnt_o <= '0;
        end else if ((mem_stall || load_use) && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed
// multi-cycle sequences and randomized traffic against a cycle model.
module tb_pipeline_ctrl;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       start;
    logic       imr;
    logic [4:0] rd, rs1, rs2;
    logic       br, exr, exw, ack;

    logic        req, pcw, ifw, flush, idb, mwb, idh, exh, err;
    logic [15:0] cnt;
    logic        s_req, s_pcw, s_ifw, s_flush, s_idb, s_mwb, s_idh, s_exh;
    logic        s_err;
    logic [3:0]  s_cnt;

    logic [7:0] ctl;
    assign ctl = {req, pcw, ifw, flush, idb, mwb, idh, exh};

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) u_dut (
        .clk_i(clk), .start_i(start),
        .IDEX_MemRead_i(imr), .IDEX_RDaddr_i(rd),
        .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
        .Branch_taken_i(br),
        .EXMEM_MemRead_i(exr), .EXMEM_MemWrite_i(exw),
        .mem_ack_i(ack), .mem_req_o(req),
        .PCWrite_o(pcw), .IFID_Write_o(ifw),
        .IFID_Flush_o(flush), .IDEX_Bubble_o(idb),
        .MEMWB_Bubble_o(mwb), .IDEX_Hold_o(idh),
        .EXMEM_Hold_o(exh), .err_o(err), .stall_cnt_o(cnt)
    );

    pipeline_ctrl #(.TIMEOUT(TMO), .CNT_W(4)) u_sat (
        .clk_i(clk), .start_i(start),
        .IDEX_MemRead_i(imr), .IDEX_RDaddr_i(rd),
        .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
        .Branch_taken_i(br),
        .EXMEM_MemRead_i(exr), .EXMEM_MemWrite_i(exw),
        .mem_ack_i(ack), .mem_req_o(s_req),
        .PCWrite_o(s_pcw), .IFID_Write_o(s_ifw),
        .IFID_Flush_o(s_flush), .IDEX_Bubble_o(s_idb),
        .MEMWB_Bubble_o(s_mwb), .IDEX_Hold_o(s_idh),
        .EXMEM_Hold_o(s_exh), .err_o(s_err), .stall_cnt_o(s_cnt)
    );

    typedef struct {
        logic       st;
        logic       imr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       exr;
        logic       exw;
        logic       ack;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic st, input logic i_mr,
                          input logic [4:0] i_rd, input logic [4:0] i_rs1,
                          input logic [4:0] i_rs2, input logic i_br,
                          input logic i_exr, input logic i_exw,
                          input logic i_ack);
        start = st;
        imr   = i_mr;
        rd    = i_rd;
        rs1   = i_rs1;
        rs2   = i_rs2;
        br    = i_br;
        exr   = i_exr;
        exw   = i_exw;
        ack   = i_ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference model: counts consecutive unacknowledged request cycles
    int  m_wait;
    bit  m_err;
    int  m_cnt;
    int  m_scnt;

    task automatic model_step();
        logic       memop, mreq, lu, stl;
        logic [7:0] e;
        memop = exr | exw;
        mreq  = start && (m_wait > 0 || (!m_err && memop));
        lu    = imr && (rd != 0) && (rd == rs1 || rd == rs2);
        stl   = (mreq && !ack) || m_err;
        if (!start)    e = 8'b0001_1100;
        else if (stl)  e = {mreq, 7'b000_0111};
        else if (lu)   e = {mreq, 7'b000_1000};
        else if (br)   e = {mreq, 7'b111_0000};
        else           e = {mreq, 7'b110_0000};
        chk("rnd_ctl", ctl, e);
        chk("rnd_err", err, m_err);
        chk("rnd_cnt", cnt, m_cnt);
        chk("rnd_cnt4", s_cnt, m_scnt);
        if (!start) begin
            m_wait = 0;
            m_err  = 0;
            m_cnt  = 0;
            m_scnt = 0;
        end else begin
            if (stl || lu) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_scnt < 15) m_scnt++;
            end
            if (!m_err && mreq) begin
                if (ack) begin
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait > TMO) begin
                        m_err  = 1;
                        m_wait = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rc, sc, n;

        // st imr rd rs1 rs2 br exr exw ack : {req,pcw,ifw,fl,idb,mwb,idh,exh}
        tbl[0]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b0001_1100};
        tbl[1]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0110_0000};
        tbl[2]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_1000};
        tbl[3]  = '{1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_1000};
        tbl[4]  = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0110_0000};
        tbl[5]  = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0110_0000};
        tbl[6]  = '{1'b1, 1'b1, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0110_0000};
        tbl[7]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0111_0000};
        tbl[8]  = '{1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_1000};
        tbl[9]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'b1110_0000};
        tbl[10] = '{1'b1, 1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b1000_1000};
        tbl[11] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'b1111_0000};

        set_in(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        #3;
        chk("reset_ctl", ctl, 8'b0001_1100);
        tick();
        chk("reset_err", err, 1'b0);
        chk("reset_cnt", cnt, 16'd0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].st, tbl[i].imr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                   tbl[i].br, tbl[i].exr, tbl[i].exw, tbl[i].ack);
            #3;
            chk($sformatf("vec%0d", i), ctl, tbl[i].exp);
            tick();
        end

        // Load acknowledged three cycles after the request
        do_reset();
        tick();
        rc = 0;
        sc = 0;
        for (int c = 0; c < 4; c++) begin
            set_in(1, 0, 0, 0, 0, 0, 1, 0, (c == 3));
            #3;
            rc += int'(req);
            sc += int'(!pcw && exh && idh && mwb);
            tick();
        end
        chk("ack3_req_cycles", rc, 4);
        chk("ack3_stall_cycles", sc, 3);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("ack3_idle_req", req, 1'b0);
        chk("ack3_cnt", cnt, 16'd3);
        tick();

        // Branch coinciding with load-use is not flushed, then flushed
        do_reset();
        set_in(1, 1, 5'd5, 5'd0, 5'd5, 1, 0, 0, 0);
        #3;
        chk("lu_br_ctl", ctl, 8'b0000_1000);
        tick();
        set_in(1, 0, 5'd5, 5'd0, 5'd5, 1, 0, 0, 0);
        #3;
        chk("br_after_lu", ctl, 8'b0111_0000);
        tick();
        set_in(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        #3;
        chk("lu_rd0", ctl, 8'b0110_0000);
        tick();
        chk("lu_cnt", cnt, 16'd1);

        // Never-acked request runs into the timeout trap
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
        n = 0;
        while (!err && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, TMO + 1);
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0);
        #3;
        chk("tmo_frozen", ctl, 8'b0000_0111);
        tick();
        tick();
        chk("tmo_sticky", err, 1'b1);
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
        #3;
        chk("tmo_rst_ctl", ctl, 8'b0001_1100);
        tick();
        chk("tmo_rst_err", err, 1'b0);

        // Reset in the second BUSY cycle
        do_reset();
        tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("busy_rst_req", req, 1'b0);
        chk("busy_rst_cnt", cnt, 16'd0);
        chk("busy_rst_err", err, 1'b0);
        tick();

        // 2^4+2 stall cycles saturate the narrow counter
        do_reset();
        tick();
        set_in(1, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0);
        for (int c = 0; c < 18; c++) tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("sat_cnt4", s_cnt, 4'd15);
        chk("sat_cnt16", cnt, 16'd18);
        tick();

        // Randomized traffic against the model
        do_reset();
        tick();
        m_wait = 0;
        m_err  = 0;
        m_cnt  = 0;
        m_scnt = 0;
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom_range(99) != 0),
                   1'($urandom),
                   5'($urandom_range(3)),
                   5'($urandom_range(3)),
                   5'($urandom_range(3)),
                   1'($urandom),
                   ($urandom_range(3) == 0),
                   ($urandom_range(5) == 0),
                   ($urandom_range(7) == 0));
            #3;
            model_step();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
